// File: rtl/aes_inv_key_sched.sv
// s_box: AES forward S-box computed as GF(2^8) inverse followed by the affine map
module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r, p, q;
    r = 8'h00;
    p = x;
    q = z;
    for (int i = 0; i < 8; i++) begin
      if (q[0]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q >> 1;
    end
    return r;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // x^254 is the multiplicative inverse (and maps 0 to 0), then the affine transform
  always_comb begin
    x2   = gmul(a, a);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// aes_inv_key_sched: expands an AES-128 key to round 10, then emits round keys 10..0
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_idx,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t       state, state_n;
  logic [127:0] key_reg, key_n;
  logic [3:0]   cnt, cnt_n, round_idx_n, rc_sel;
  logic         key_valid_n, busy_n, done_n;
  logic [31:0]  w0, w1, w2, w3, p1, p2, p3, sub_in, sub_out, t;
  logic [7:0]   rcon;
  logic [127:0] fwd, bwd;

  assign {w0, w1, w2, w3} = key_reg;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign sub_in = (state == EMIT) ? {p3[23:0], p3[31:24]} : {w3[23:0], w3[31:24]};
  assign rc_sel = (state == EMIT) ? round_idx - 4'd1 : cnt;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    s_box u_sbox (.a(sub_in[8*i +: 8]), .y(sub_out[8*i +: 8]));
  end

  // Round constant lookup; codes 10..15 never occur and yield zero
  always_comb begin
    case (rc_sel)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t   = sub_out ^ {rcon, 24'h0};
  assign fwd = {w0 ^ t, w0 ^ t ^ w1, w0 ^ t ^ w1 ^ w2, w0 ^ t ^ w1 ^ w2 ^ w3};
  assign bwd = {w0 ^ t, p1, p2, p3};

  // Next-state and next-output logic; done is a single-cycle pulse by default
  always_comb begin
    state_n     = state;
    key_n       = key_reg;
    cnt_n       = cnt;
    round_idx_n = round_idx;
    key_valid_n = key_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: if (start) begin
        key_n   = key_in;
        cnt_n   = 4'd0;
        busy_n  = 1'b1;
        state_n = EXPAND;
      end
      EXPAND: begin
        key_n = fwd;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd9) begin
          state_n     = EMIT;
          round_idx_n = 4'd10;
          key_valid_n = 1'b1;
        end
      end
      EMIT: if (key_ready) begin
        if (round_idx != 4'd0) begin
          key_n       = bwd;
          round_idx_n = round_idx - 4'd1;
        end else begin
          state_n     = IDLE;
          key_valid_n = 1'b0;
          busy_n      = 1'b0;
          done_n      = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      cnt       <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      key_reg   <= key_n;
      cnt       <= cnt_n;
      round_idx <= round_idx_n;
      key_valid <= key_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  assign key_out = key_reg;
endmodule
